// File: rtl/systolic_sparse_feeder.sv
// Block sequencer for the 14x14 weight-stationary sparse systolic array: clear, weight load, stream, flush.
// Define FEEDER_PERF_CNT_EN to add the perf_clr input and saturating skip/stall/busy counters.
//
// state  | meaning
// IDLE   | ready for a descriptor; skipped zero blocks retire here
// CLR    | one-cycle accumulator clear for the first block of a tile
// LOAD   | weight rows read from the buffer and shifted into the array
// STREAM | activation vectors forwarded under block_valid
// FLUSH  | zero vectors drain the skew registers and PE chain
// DONE   | one-cycle tile_done pulse
module systolic_sparse_feeder #(
    parameter int N_ROWS = 14,
    parameter int N_COLS = 14,
    parameter int DATA_W = 8,
    parameter int MAX_M  = 256,
    parameter int M_W    = $clog2(MAX_M + 1),
    parameter int A_W    = $clog2(N_ROWS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       desc_valid,
    output logic                       desc_ready,
    input  logic                       desc_zero,
    input  logic                       desc_first,
    input  logic                       desc_last,
    input  logic [M_W-1:0]             desc_mlen,
    output logic                       wgt_rd_en,
    output logic [A_W-1:0]             wgt_rd_addr,
    input  logic [N_COLS*DATA_W-1:0]   wgt_rd_data,
    input  logic                       act_valid,
    output logic                       act_ready,
    input  logic [N_ROWS*DATA_W-1:0]   act_data,
    output logic                       arr_block_valid,
    output logic                       arr_load_weight,
    output logic                       arr_clr,
    output logic [N_ROWS*DATA_W-1:0]   arr_a_flat,
    output logic [N_COLS*DATA_W-1:0]   arr_b_flat,
    output logic                       busy,
`ifdef FEEDER_PERF_CNT_EN
    input  logic                       perf_clr,
    output logic [31:0]                perf_skip_cnt,
    output logic [31:0]                perf_stall_cnt,
    output logic [31:0]                perf_busy_cnt,
`endif
    output logic                       tile_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLR    = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_FLUSH  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int LC_W   = $clog2(N_ROWS + 1);
    localparam int FL_LEN = N_ROWS + N_COLS - 2;
    localparam int FC_W   = $clog2(FL_LEN);
    localparam logic [LC_W-1:0] LD_LAST = LC_W'(N_ROWS);
    localparam logic [FC_W-1:0] FL_LAST = FC_W'(FL_LEN - 1);

    logic [2:0]      state_q, state_d;
    logic            zero_q, zero_d;
    logic            last_q, last_d;
    logic [M_W-1:0]  mlen_q, mlen_d;
    logic [LC_W-1:0] ld_cnt_q, ld_cnt_d;
    logic [M_W-1:0]  beat_q, beat_d;
    logic [FC_W-1:0] fl_cnt_q, fl_cnt_d;

    always_comb begin
        state_d         = state_q;
        zero_d          = zero_q;
        last_d          = last_q;
        mlen_d          = mlen_q;
        ld_cnt_d        = ld_cnt_q;
        beat_d          = beat_q;
        fl_cnt_d        = fl_cnt_q;
        desc_ready      = 1'b0;
        wgt_rd_en       = 1'b0;
        wgt_rd_addr     = '0;
        act_ready       = 1'b0;
        arr_block_valid = 1'b0;
        arr_load_weight = 1'b0;
        arr_clr         = 1'b0;
        arr_a_flat      = '0;
        arr_b_flat      = '0;
        tile_done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                desc_ready = 1'b1;
                if (desc_valid) begin
                    zero_d = desc_zero;
                    last_d = desc_last;
                    mlen_d = desc_mlen;
                    if (desc_first)     state_d = S_CLR;
                    else if (!desc_zero) state_d = S_LOAD;
                    else if (desc_last)  state_d = S_DONE;
                end
            end
            S_CLR: begin
                arr_clr = 1'b1;
                if (zero_q) state_d = last_q ? S_DONE : S_IDLE;
                else        state_d = S_LOAD;
            end
            S_LOAD: begin
                if (ld_cnt_q < LD_LAST) begin
                    wgt_rd_en   = 1'b1;
                    wgt_rd_addr = ld_cnt_q[A_W-1:0];
                end
                // Buffer data lags the read strobe by one cycle, so the array sees row k at count k+1.
                if (ld_cnt_q != '0) begin
                    arr_load_weight = 1'b1;
                    arr_b_flat      = wgt_rd_data;
                end
                if (ld_cnt_q == LD_LAST) begin
                    ld_cnt_d = '0;
                    state_d  = (mlen_q != '0) ? S_STREAM : S_FLUSH;
                end else begin
                    ld_cnt_d = ld_cnt_q + 1'b1;
                end
            end
            S_STREAM: begin
                act_ready       = 1'b1;
                arr_block_valid = act_valid;
                if (act_valid) begin
                    arr_a_flat = act_data;
                    if (M_W'(beat_q + 1'b1) == mlen_q) begin
                        beat_d  = '0;
                        state_d = S_FLUSH;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                arr_block_valid = 1'b1;
                if (fl_cnt_q == FL_LAST) begin
                    fl_cnt_d = '0;
                    state_d  = last_q ? S_DONE : S_IDLE;
                end else begin
                    fl_cnt_d = fl_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                tile_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            zero_q   <= 1'b0;
            last_q   <= 1'b0;
            mlen_q   <= '0;
            ld_cnt_q <= '0;
            beat_q   <= '0;
            fl_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            zero_q   <= zero_d;
            last_q   <= last_d;
            mlen_q   <= mlen_d;
            ld_cnt_q <= ld_cnt_d;
            beat_q   <= beat_d;
            fl_cnt_q <= fl_cnt_d;
        end
    end

    assign busy = (state_q != S_IDLE);

`ifdef FEEDER_PERF_CNT_EN
    logic [31:0] perf_skip_q, perf_skip_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_busy_q, perf_busy_d;

    always_comb begin
        perf_skip_d  = perf_skip_q;
        perf_stall_d = perf_stall_q;
        perf_busy_d  = perf_busy_q;
        if (perf_clr) begin
            perf_skip_d  = '0;
            perf_stall_d = '0;
            perf_busy_d  = '0;
        end else begin
            if (state_q == S_IDLE && desc_valid && desc_zero && perf_skip_q != '1)
                perf_skip_d = perf_skip_q + 1'b1;
            if (state_q == S_STREAM && !act_valid && perf_stall_q != '1)
                perf_stall_d = perf_stall_q + 1'b1;
            if (busy && perf_busy_q != '1)
                perf_busy_d = perf_busy_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_skip_q  <= '0;
            perf_stall_q <= '0;
            perf_busy_q  <= '0;
        end else begin
            perf_skip_q  <= perf_skip_d;
            perf_stall_q <= perf_stall_d;
            perf_busy_q  <= perf_busy_d;
        end
    end

    assign perf_skip_cnt  = perf_skip_q;
    assign perf_stall_cnt = perf_stall_q;
    assign perf_busy_cnt  = perf_busy_q;
`endif

endmodule

// File: tb/tb_systolic_sparse_feeder.sv
// Randomized bench for systolic_sparse_feeder against a timeline model and an abstract array accumulator.
module tb_systolic_sparse_feeder;
    localparam int NR   = 14;
    localparam int NC   = 14;
    localparam int DW   = 8;
    localparam int MAXM = 256;
    localparam int MW   = $clog2(MAXM + 1);
    localparam int AW   = $clog2(NR);
    localparam int MAXB = 8;
    localparam int MAXV = 8;
    localparam int FL   = NR + NC - 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic desc_valid, desc_ready, desc_zero, desc_first, desc_last;
    logic [MW-1:0] desc_mlen;
    logic wgt_rd_en;
    logic [AW-1:0] wgt_rd_addr;
    logic [NC*DW-1:0] wgt_rd_data;
    logic act_valid, act_ready;
    logic [NR*DW-1:0] act_data;
    logic arr_block_valid, arr_load_weight, arr_clr;
    logic [NR*DW-1:0] arr_a_flat;
    logic [NC*DW-1:0] arr_b_flat;
    logic busy, tile_done;
`ifdef FEEDER_PERF_CNT_EN
    logic perf_clr;
    logic [31:0] perf_skip_cnt, perf_stall_cnt, perf_busy_cnt;
`endif

    always #5 clk = ~clk;

    systolic_sparse_feeder dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_zero(desc_zero),
        .desc_first(desc_first), .desc_last(desc_last), .desc_mlen(desc_mlen),
        .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .arr_block_valid(arr_block_valid), .arr_load_weight(arr_load_weight), .arr_clr(arr_clr),
        .arr_a_flat(arr_a_flat), .arr_b_flat(arr_b_flat), .busy(busy),
`ifdef FEEDER_PERF_CNT_EN
        .perf_clr(perf_clr), .perf_skip_cnt(perf_skip_cnt),
        .perf_stall_cnt(perf_stall_cnt), .perf_busy_cnt(perf_busy_cnt),
`endif
        .tile_done(tile_done)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] rnd_row();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[NR*DW-1:0];
    endfunction

    // Fixed-latency weight buffer; garbage when not read so misaligned capture shows up.
    logic [NC*DW-1:0] wmem [NR];
    always @(posedge clk) begin
        if (wgt_rd_en) wgt_rd_data <= wmem[wgt_rd_addr];
        else           wgt_rd_data <= rnd_row();
    end

    // Block descriptors and data
    bit               b_first [MAXB];
    bit               b_zero  [MAXB];
    bit               b_last  [MAXB];
    int               b_m     [MAXB];
    int               b_gap   [MAXB][MAXV];
    logic [NR*DW-1:0] b_vec   [MAXB][MAXV];
    logic [NC*DW-1:0] b_wt    [MAXB][NR];
    int               ref_acc [NC];

    // Abstract array: rows latched in load order, each valid vector adds a . W to the column sums.
    logic [NC*DW-1:0] wmod [NR];
    int acc [NC];
    int wptr;

    function automatic int mdot(input logic [NR*DW-1:0] a, input int j);
        int s;
        byte x, w;
        s = 0;
        for (int i = 0; i < NR; i++) begin
            x = a[i*DW +: DW];
            w = wmod[i][j*DW +: DW];
            s += int'(x) * int'(w);
        end
        return s;
    endfunction

    function automatic int rdot(input int blk, input int v, input int j);
        int s;
        byte x, w;
        s = 0;
        for (int i = 0; i < NR; i++) begin
            x = b_vec[blk][v][i*DW +: DW];
            w = b_wt[blk][i][j*DW +: DW];
            s += int'(x) * int'(w);
        end
        return s;
    endfunction

    int cyc = 0;
    int t0;
    bit t0_set;
    int n_clr, n_done, n_lw, n_lw_runs, n_bv, n_rd, n_rdy_lo, n_stall, n_a_bad;
    int f_clr, f_lw, l_lw, f_bv, l_bv, f_done;
    bit lw_prev;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int rel;
        if (!rst_n) begin
            for (int j = 0; j < NC; j++) acc[j] = 0;
            wptr = 0;
            lw_prev = 0;
        end else begin
            if (!t0_set && desc_valid && desc_ready) begin
                t0 = cyc;
                t0_set = 1;
            end
            rel = cyc - t0;
            if (t0_set) begin
                if (arr_clr) begin
                    n_clr++; f_clr = rel;
                    for (int j = 0; j < NC; j++) acc[j] = 0;
                end
                if (arr_load_weight) begin
                    if (!lw_prev) n_lw_runs++;
                    if (n_lw == 0) f_lw = rel;
                    l_lw = rel;
                    n_lw++;
                    wmod[wptr] = arr_b_flat;
                    wptr = (wptr == NR - 1) ? 0 : wptr + 1;
                end
                if (arr_block_valid) begin
                    if (n_bv == 0) f_bv = rel;
                    l_bv = rel;
                    n_bv++;
                    for (int j = 0; j < NC; j++) acc[j] += mdot(arr_a_flat, j);
                end
                if (wgt_rd_en) n_rd++;
                if (!desc_ready) n_rdy_lo++;
                if (act_ready && !act_valid) n_stall++;
                if (arr_a_flat != '0 && !(act_ready && act_valid)) n_a_bad++;
                if (tile_done) begin
                    if (n_done == 0) f_done = rel;
                    n_done++;
                end
            end
            lw_prev = arr_load_weight;
        end
    end

    task automatic mon_clear();
        t0_set = 0; t0 = 0;
        n_clr = 0; n_done = 0; n_lw = 0; n_lw_runs = 0; n_bv = 0;
        n_rd = 0; n_rdy_lo = 0; n_stall = 0; n_a_bad = 0;
        f_clr = -1; f_lw = -1; l_lw = -1; f_bv = -1; l_bv = -1; f_done = -1;
    endtask

    task automatic gen_block(input int i, input bit f, input bit z, input bit l, input int m);
        b_first[i] = f; b_zero[i] = z; b_last[i] = l; b_m[i] = m;
        for (int v = 0; v < MAXV; v++) begin
            b_gap[i][v] = 0;
            b_vec[i][v] = rnd_row();
        end
        for (int r = 0; r < NR; r++) b_wt[i][r] = rnd_row();
    endtask

    task automatic set_desc(input int i);
        desc_first = b_first[i];
        desc_zero  = b_zero[i];
        desc_last  = b_last[i];
        desc_mlen  = MW'(b_m[i]);
    endtask

    task automatic chk_acc(input string tag);
        for (int j = 0; j < NC; j++) chk(tag, acc[j], ref_acc[j]);
    endtask

    // Presents nblk descriptors back to back and feeds each block's vectors with its gap pattern.
    task automatic run_seq(input int nblk);
        int bi, cur, beat, gap_left, cyc_n;
        bit hs_d, hs_a, fin;
        bi = 0; cur = 0; beat = 0; gap_left = 0; cyc_n = 0; fin = 0;
        set_desc(0);
        desc_valid = 1;
        act_valid = 0;
        while (!fin && cyc_n < 3000) begin
            @(negedge clk);
            hs_d = desc_valid && desc_ready;
            hs_a = act_valid && act_ready;
            if (bi == nblk && !busy) begin
                fin = 1;
            end else begin
                @(posedge clk); #1;
                cyc_n++;
                if (hs_d) begin
                    cur = bi;
                    for (int r = 0; r < NR; r++) wmem[r] = b_wt[cur][r];
                    if (b_first[cur]) for (int j = 0; j < NC; j++) ref_acc[j] = 0;
                    if (!b_zero[cur])
                        for (int v = 0; v < b_m[cur]; v++)
                            for (int j = 0; j < NC; j++) ref_acc[j] += rdot(cur, v, j);
                    beat = 0; gap_left = 0;
                    bi++;
                    if (bi < nblk) set_desc(bi);
                    else desc_valid = 0;
                end
                if (hs_a) begin
                    beat++;
                    gap_left = (beat < b_m[cur]) ? b_gap[cur][beat] : 0;
                end
                if (gap_left > 0) begin
                    act_valid = 0; act_data = rnd_row(); gap_left--;
                end else if (bi > 0 && !b_zero[cur] && beat < b_m[cur]) begin
                    act_valid = 1; act_data = b_vec[cur][beat];
                end else begin
                    act_valid = 0; act_data = rnd_row();
                end
            end
        end
        @(posedge clk); #1;
        act_valid = 0;
        desc_valid = 0;
        chk("seq_complete", fin, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, exp_lw, exp_bv, exp_st;
        desc_valid = 0; desc_zero = 0; desc_first = 0; desc_last = 0; desc_mlen = '0;
        act_valid = 1; act_data = rnd_row();
`ifdef FEEDER_PERF_CNT_EN
        perf_clr = 0;
`endif
        for (int r = 0; r < NR; r++) wmem[r] = rnd_row();
        for (int j = 0; j < NC; j++) ref_acc[j] = 0;
        mon_clear();

        // Reset: all outputs low except desc_ready, even with activations offered
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {desc_ready, busy, wgt_rd_en, act_ready, arr_clr, arr_load_weight,
                            arr_block_valid, tile_done, |arr_a_flat, |arr_b_flat, |wgt_rd_addr},
            11'b100_0000_0000);
        @(negedge clk);
        rst_n = 1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_after_rst", {busy, desc_ready, wgt_rd_en, act_ready}, 4'b0100);
        act_valid = 0;

        // Single first+last block, mlen 3, no stalls
        mon_clear();
        gen_block(0, 1, 0, 1, 3);
        run_seq(1);
        chk("single_clr_cyc", f_clr, 1);
        chk("single_clr_cnt", n_clr, 1);
        chk("single_lw_first", f_lw, 3);
        chk("single_lw_last", l_lw, 16);
        chk("single_lw_cnt", n_lw, NR);
        chk("single_lw_runs", n_lw_runs, 1);
        chk("single_rd_cnt", n_rd, NR);
        chk("single_bv_first", f_bv, 17);
        chk("single_bv_last", l_bv, 45);
        chk("single_bv_cnt", n_bv, 3 + FL);
        chk("single_done_cyc", f_done, 46);
        chk("single_done_cnt", n_done, 1);
        chk("single_a_masked", n_a_bad, 0);
        chk_acc("single_acc");

        // Activation stall: two idle cycles after beat 1
        mon_clear();
        gen_block(0, 1, 0, 1, 3);
        b_gap[0][1] = 2;
        run_seq(1);
        chk("stall_cnt", n_stall, 2);
        chk("stall_bv_first", f_bv, 17);
        chk("stall_bv_last", l_bv, 47);
        chk("stall_bv_cnt", n_bv, 3 + FL);
        chk("stall_done_cyc", f_done, 48);
        chk("stall_a_masked", n_a_bad, 0);
        chk_acc("stall_acc");

        // Zero, non-first, non-last block is retired in the accept cycle
        mon_clear();
        gen_block(0, 0, 1, 0, 2);
        run_seq(1);
        chk("skip_ready_now", desc_ready, 1);
        chk("skip_ready_lo", n_rdy_lo, 0);
        chk("skip_rd", n_rd, 0);
        chk("skip_lw", n_lw, 0);
        chk("skip_bv", n_bv, 0);
        chk("skip_done", n_done, 0);
`ifdef FEEDER_PERF_CNT_EN
        chk("skip_perf", perf_skip_cnt, 1);
`endif

        // Zero, non-first, last block: tile_done in cycle 1
        mon_clear();
        gen_block(0, 0, 1, 1, 0);
        run_seq(1);
        chk("zlast_done_cyc", f_done, 1);
        chk("zlast_done_cnt", n_done, 1);
        chk("zlast_lw", n_lw, 0);

        // Non-first non-zero block: one cycle earlier, accumulates onto prior sums
        mon_clear();
        gen_block(0, 0, 0, 1, 2);
        run_seq(1);
        chk("nf_clr_cnt", n_clr, 0);
        chk("nf_lw_first", f_lw, 2);
        chk("nf_lw_last", l_lw, 15);
        chk("nf_bv_first", f_bv, 16);
        chk("nf_done_cyc", f_done, 16 + 2 + FL);
        chk_acc("nf_acc");

        // Multi-block tile: non-zero first, zero, non-zero last
        mon_clear();
        gen_block(0, 1, 0, 0, 4);
        gen_block(1, 0, 1, 0, 3);
        gen_block(2, 0, 0, 1, 2);
        run_seq(3);
        chk("multi_clr_cnt", n_clr, 1);
        chk("multi_done_cnt", n_done, 1);
        chk("multi_lw_cnt", n_lw, 2 * NR);
        chk("multi_lw_runs", n_lw_runs, 2);
        chk("multi_bv_cnt", n_bv, (4 + FL) + (2 + FL));
        chk_acc("multi_acc");

        // Reset in the middle of LOAD (row counter at 5)
        mon_clear();
        gen_block(0, 1, 0, 1, 2);
        for (int r = 0; r < NR; r++) wmem[r] = b_wt[0][r];
        set_desc(0);
        desc_valid = 1;
        @(posedge clk); #1;
        desc_valid = 0;
        repeat (6) @(posedge clk);
        #2;
        chk("ld5_rd_en", wgt_rd_en, 1);
        chk("ld5_lw", arr_load_weight, 1);
        rst_n = 0;
        #1;
        chk("rst_mid_strobes", {wgt_rd_en, arr_load_weight, busy, desc_ready}, 4'b0001);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        mon_clear();
        gen_block(0, 1, 0, 1, 3);
        run_seq(1);
        chk("post_rst_lw_cnt", n_lw, NR);
        chk("post_rst_lw_first", f_lw, 3);
        chk("post_rst_done_cyc", f_done, 46);
        chk_acc("post_rst_acc");

        // Randomized tiles
        for (int t = 0; t < 6; t++) begin
            nb = 1 + int'($urandom % 3);
            exp_lw = 0; exp_bv = 0; exp_st = 0;
            for (int b = 0; b < nb; b++) begin
                gen_block(b, b == 0, ($urandom % 3) == 0, b == nb - 1, int'($urandom % 6));
                for (int k = 1; k < b_m[b]; k++) b_gap[b][k] = int'($urandom % 3);
                if (!b_zero[b]) begin
                    exp_lw += NR;
                    exp_bv += b_m[b] + FL;
                    for (int k = 1; k < b_m[b]; k++) exp_st += b_gap[b][k];
                end
            end
            mon_clear();
            run_seq(nb);
            chk("rnd_clr_cnt", n_clr, 1);
            chk("rnd_done_cnt", n_done, 1);
            chk("rnd_lw_cnt", n_lw, exp_lw);
            chk("rnd_bv_cnt", n_bv, exp_bv);
            chk("rnd_stall_cnt", n_stall, exp_st);
            chk("rnd_a_masked", n_a_bad, 0);
            chk_acc("rnd_acc");
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
